axi2ahb_wctrl: RTL and testbench
================================

Name: axi2ahb_wctrl

Overview:
Write-command stage of the AXI-to-AHB bridge. It accepts one AXI AW burst at a time and drives the AHB address phase (HADDR/HTRANS/HSIZE/HBURST/HWRITE) beat by beat. It paces the downstream write-data stage by popping its WDATA FIFO in lock-step with accepted AHB address beats. It supplies the burst ID and error flag that the data stage uses to build the B response.

Parameters:
AXI_ID_WIDTH, 1, width of AWID / cmd_id_o
AXI_ADDR_WIDTH, 32, width of AWADDR / HADDR
AXI_DATA_WIDTH, 32, data-bus width; legal values 32/64/128; fixes max legal AWSIZE = log2(AXI_DATA_WIDTH/8)

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, synchronous, active-low
AWID  in  AXI_ID_WIDTH  burst ID
AWADDR  in  AXI_ADDR_WIDTH  start address
AWLEN  in  8  beats-1
AWSIZE  in  3  bytes/beat = 1<<AWSIZE
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
AWVALID  in  1  AW valid
AWREADY  out  1  AW ready
HADDR  out  AXI_ADDR_WIDTH  AHB address
HTRANS  out  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE  out  1  constant 1 while a burst is active, else 0
HSIZE  out  3  latched AWSIZE
HBURST  out  3  AHB burst type
HREADY  in  1  AHB ready
cmd_id_o  out  AXI_ID_WIDTH  ID of current burst, to data stage
cmd_error_o  out  1  burst will get SLVERR, to data stage
ctrl_wdata_last_i  in  1  WLAST of the FIFO head entry
ctrl_wdata_valid_o  out  1  pop strobe to the data-stage FIFO
ctrl_wdata_ready_i  in  1  data-stage FIFO non-empty

Behaviour:
- Reset (ARESETN=0 at posedge): state=IDLE. AWREADY=1, HTRANS=00, HWRITE=0, HADDR=0, HSIZE=0, HBURST=000, cmd_id_o=0, cmd_error_o=0, ctrl_wdata_valid_o=0. Reset mid-burst abandons the burst; no partial state survives.
- FSM states: IDLE, ADDR, DRAIN, TAIL.
- IDLE: AWREADY=1. On AWVALID, latch id/addr/len/size/burst and set beat_cnt=AWLEN.
  - Error check: AWSIZE > max, or AWBURST=11, or WRAP with AWLEN not in {1,3,7,15}, or WRAP with AWADDR not aligned to 1<<AWSIZE.
  - Error: cmd_error_o<=1, go to DRAIN. Otherwise cmd_error_o<=0, go to ADDR.
  - cmd_id_o<=AWID in both cases. AWREADY is 0 in all states except IDLE.
- ADDR: beat offered when ctrl_wdata_ready_i=1.
  - HTRANS: NONSEQ for the first beat, SEQ for later beats. With no data: IDLE before the first beat, BUSY between beats. FIXED and WRAP2 issue every beat as NONSEQ.
  - Beat accepted when HTRANS is NONSEQ/SEQ and HREADY=1. In that same cycle ctrl_wdata_valid_o=1 (combinational); no other pops occur in ADDR.
  - On accept: beat_cnt decrements and HADDR updates next cycle. FIXED: unchanged. INCR: +(1<<size). WRAP: +(1<<size) wrapping within an aligned ((len+1)<<size) window.
  - HREADY=0 holds HADDR/HTRANS/HBURST stable.
- HBURST: AWLEN=0 gives SINGLE 000. INCR gives 001. WRAP len 3/7/15 gives 010/100/110. FIXED and WRAP2 give SINGLE.
- WLAST check: on each pop, ctrl_wdata_last_i must equal (beat_cnt==0). A mismatch sets cmd_error_o sticky for the rest of the burst. The burst still ends on beat count, never on WLAST.
- DRAIN: HTRANS=IDLE, HWRITE=0. ctrl_wdata_valid_o=ctrl_wdata_ready_i. beat_cnt decrements on each pop.
- Last pop (beat_cnt==0) in ADDR or DRAIN: go to TAIL with tail_cnt=3.
- TAIL: HTRANS=IDLE. cmd_id_o/cmd_error_o held, to cover the data stage's 3-cycle response pipeline. tail_cnt decrements; at 0 go to IDLE.
- cmd_id_o/cmd_error_o change only on AW acceptance (or the sticky WLAST set). Throughput is one burst in flight; minimum AW-to-AW spacing is len+1+4 cycles.

Optional Feature:
AXI2AHB_WRAP_EN
- Defined: WRAP bursts are supported as above.
- Undefined: AWBURST=10 is treated as an error (DRAIN path, SLVERR). WRAP address logic and the WRAP HBURST encodings are removed.

Test Plan:
- INCR, AWADDR=0x100, AWLEN=3, AWSIZE=2, FIFO pre-filled -> HTRANS NONSEQ,SEQ,SEQ,SEQ; HADDR 0x100/104/108/10C; HBURST=001; 4 pops; cmd_error_o=0; AWREADY back after 4 TAIL+IDLE cycles.
- Same burst, HREADY=0 for 2 cycles on beat 2 -> HADDR=0x104 held 3 cycles; no extra pop.
- FIFO empty between beats 1 and 2 (ctrl_wdata_ready_i=0 for 3 cycles) -> HTRANS=BUSY for 3 cycles, then SEQ 0x104.
- AWSIZE=3 with 32-bit data, AWLEN=1 -> no AHB NONSEQ; 2 pops; cmd_error_o=1.
- WRAP, AWADDR=0x38, AWLEN=3, AWSIZE=2 (macro defined) -> HADDR 0x38,0x3C,0x30,0x34; HBURST=010. Macro undefined -> DRAIN, cmd_error_o=1.
- ctrl_wdata_last_i=1 on beat 1 of a 4-beat INCR -> cmd_error_o goes 1 next cycle; 4 beats still issued.

Source files
------------

// File: rtl/axi2ahb_wctrl.sv
// axi2ahb_wctrl: AXI AW burst to AHB write address-phase sequencer, pacing the write-data FIFO.
// Optional WRAP burst support is enabled by defining AXI2AHB_WRAP_EN.
module axi2ahb_wctrl #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [AXI_ID_WIDTH-1:0]   AWID,
    input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    output logic [AXI_ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]                HTRANS,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    input  logic                      HREADY,
    output logic [AXI_ID_WIDTH-1:0]   cmd_id_o,
    output logic                      cmd_error_o,
    input  logic                      ctrl_wdata_last_i,
    output logic                      ctrl_wdata_valid_o,
    input  logic                      ctrl_wdata_ready_i
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));
    localparam logic [AXI_ADDR_WIDTH-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, ADDR, DRAIN, TAIL} state_t;

    state_t                    state, state_n;
    logic [7:0]                len_q, beat_cnt;
    logic [1:0]                burst_q, tail_cnt;
    logic                      aw_fire, aw_err, pop, last_pop, first, nseq_only;
    logic [2:0]                hburst_n;
    logic [AXI_ADDR_WIDTH-1:0] step, addr_n;
`ifdef AXI2AHB_WRAP_EN
    logic [AXI_ADDR_WIDTH-1:0] wmask;
`endif

    always_comb begin
        aw_fire   = state == IDLE && AWVALID;
`ifdef AXI2AHB_WRAP_EN
        aw_err    = AWSIZE > MAX_SIZE || AWBURST == 2'b11 ||
                    (AWBURST == 2'b10 && (!(AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                                          (AWADDR & ((ONE << AWSIZE) - ONE)) != '0));
        hburst_n  = AWLEN == 8'd0    ? 3'b000 :
                    AWBURST == 2'b01 ? 3'b001 :
                    AWBURST != 2'b10 ? 3'b000 :
                    AWLEN == 8'd3    ? 3'b010 :
                    AWLEN == 8'd7    ? 3'b100 :
                    AWLEN == 8'd15   ? 3'b110 : 3'b000;
`else
        aw_err    = AWSIZE > MAX_SIZE || AWBURST[1];
        hburst_n  = (AWLEN != 8'd0 && AWBURST == 2'b01) ? 3'b001 : 3'b000;
`endif
        first     = beat_cnt == len_q;
        // FIXED and two-beat WRAP have no legal AHB SEQ form, so every beat restarts
        nseq_only = burst_q == 2'b00 || (burst_q == 2'b10 && len_q == 8'd1);
        HTRANS    = state != ADDR       ? 2'b00 :
                    ctrl_wdata_ready_i  ? ((first || nseq_only) ? 2'b10 : 2'b11) :
                    first               ? 2'b00 : 2'b01;
        pop       = state == ADDR  ? (ctrl_wdata_ready_i && HREADY) :
                    state == DRAIN ? ctrl_wdata_ready_i : 1'b0;
        last_pop  = pop && beat_cnt == 8'd0;
        step      = ONE << HSIZE;
`ifdef AXI2AHB_WRAP_EN
        wmask     = ((AXI_ADDR_WIDTH'(len_q) + ONE) << HSIZE) - ONE;
        addr_n    = burst_q == 2'b00 ? HADDR :
                    burst_q == 2'b10 ? ((HADDR & ~wmask) | ((HADDR + step) & wmask)) :
                    HADDR + step;
`else
        addr_n    = burst_q == 2'b00 ? HADDR : HADDR + step;
`endif
        AWREADY            = state == IDLE;
        HWRITE             = state == ADDR;
        ctrl_wdata_valid_o = pop;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:        state_n = AWVALID ? (aw_err ? DRAIN : ADDR) : IDLE;
            ADDR, DRAIN: state_n = last_pop ? TAIL : state;
            TAIL:        state_n = tail_cnt == 2'd1 ? IDLE : TAIL;
            default:     state_n = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state       <= IDLE;
            HADDR       <= '0;
            HSIZE       <= '0;
            HBURST      <= '0;
            cmd_id_o    <= '0;
            cmd_error_o <= 1'b0;
            len_q       <= '0;
            beat_cnt    <= '0;
            burst_q     <= '0;
            tail_cnt    <= '0;
        end else begin
            state <= state_n;
            if (aw_fire) begin
                HADDR       <= AWADDR;
                HSIZE       <= AWSIZE;
                HBURST      <= hburst_n;
                len_q       <= AWLEN;
                beat_cnt    <= AWLEN;
                burst_q     <= AWBURST;
                cmd_id_o    <= AWID;
                cmd_error_o <= aw_err;
            end
            // WLAST disagreeing with the beat count poisons the response but never ends the burst
            if (pop) begin
                beat_cnt <= beat_cnt - 8'd1;
                if (ctrl_wdata_last_i != (beat_cnt == 8'd0))
                    cmd_error_o <= 1'b1;
            end
            if (pop && state == ADDR)
                HADDR <= addr_n;
            if (last_pop)
                tail_cnt <= 2'd3;
            else if (state == TAIL)
                tail_cnt <= tail_cnt - 2'd1;
        end
    end
endmodule

// File: tb/tb_axi2ahb_wctrl.sv
// tb_axi2ahb_wctrl: randomized scoreboard bench for axi2ahb_wctrl; honours AXI2AHB_WRAP_EN.
module tb_axi2ahb_wctrl;
    localparam int IDW  = 2;
    localparam int MAXS = 2;

    logic           ACLK = 1'b0, ARESETN = 1'b0;
    logic [IDW-1:0] AWID = '0;
    logic [31:0]    AWADDR = '0;
    logic [7:0]     AWLEN = '0;
    logic [2:0]     AWSIZE = '0;
    logic [1:0]     AWBURST = '0;
    logic           AWVALID = 1'b0, AWREADY;
    logic [31:0]    HADDR;
    logic [1:0]     HTRANS;
    logic           HWRITE;
    logic [2:0]     HSIZE, HBURST;
    logic           HREADY = 1'b1;
    logic [IDW-1:0] cmd_id_o;
    logic           cmd_error_o;
    logic           ctrl_wdata_last_i = 1'b0, ctrl_wdata_valid_o, ctrl_wdata_ready_i = 1'b0;

    axi2ahb_wctrl #(.AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HREADY(HREADY), .cmd_id_o(cmd_id_o), .cmd_error_o(cmd_error_o),
        .ctrl_wdata_last_i(ctrl_wdata_last_i), .ctrl_wdata_valid_o(ctrl_wdata_valid_o),
        .ctrl_wdata_ready_i(ctrl_wdata_ready_i)
    );

    always #5 ACLK = ~ACLK;

    typedef struct { logic [31:0] addr; logic [1:0] trans; logic [2:0] burst; logic [2:0] size; } beat_t;
    typedef struct { logic [IDW-1:0] id; logic err; logic err_final; int len; int burst; } cmd_t;

    beat_t beat_q[$];
    cmd_t  cmd_q[$];
    logic  src_q[$];
    logic  fifo_q[$];
    int    total = 0, bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s @%0t", name, $time);
    endtask

    task automatic check_reset();
        check("rst_awready", AWREADY, 1);
        check("rst_htrans", HTRANS, 0);
        check("rst_hwrite", HWRITE, 0);
        check("rst_haddr", HADDR, 0);
        check("rst_hsize", HSIZE, 0);
        check("rst_hburst", HBURST, 0);
        check("rst_cmd_id", cmd_id_o, 0);
        check("rst_cmd_err", cmd_error_o, 0);
        check("rst_pop", ctrl_wdata_valid_o, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!AWREADY && n < 400);
        if (!AWREADY) flag("awready_timeout");
    endtask

    // Reference model: expected beats come straight from AXI address arithmetic
    task automatic issue(input int br, input logic [31:0] a, input int len, input int size, input int flip);
        cmd_t        c;
        beat_t       b;
        bit          err;
        logic [31:0] tot, base;
        wait_idle();
        err = size > MAXS || br == 3;
`ifdef AXI2AHB_WRAP_EN
        if (br == 2 && (!(len == 1 || len == 3 || len == 7 || len == 15) || a % (32'd1 << size) != 0)) err = 1;
`else
        if (br == 2) err = 1;
`endif
        @(posedge ACLK);
        #1;
        if (!err)
            for (int i = 0; i <= len; i++) begin
                tot  = (len + 1) << size;
                base = a - a % tot;
                b.addr  = br == 0 ? a : br == 1 ? a + (i << size) : base + (a - base + (i << size)) % tot;
                b.trans = (i == 0 || br == 0 || (br == 2 && len == 1)) ? 2'b10 : 2'b11;
                b.burst = len == 0 ? 3'd0 : br == 1 ? 3'd1 : br != 2 ? 3'd0 :
                          len == 3 ? 3'd2 : len == 7 ? 3'd4 : len == 15 ? 3'd6 : 3'd0;
                b.size  = 3'(size);
                beat_q.push_back(b);
            end
        for (int i = 0; i <= len; i++) src_q.push_back((i == len) ^ (i == flip));
        c.id        = IDW'($urandom_range(0, 3));
        c.err       = err;
        c.err_final = err || (flip >= 0 && flip <= len);
        c.len       = len;
        c.burst     = br;
        cmd_q.push_back(c);
        AWID    = c.id;
        AWADDR  = a;
        AWLEN   = 8'(len);
        AWSIZE  = 3'(size);
        AWBURST = 2'(br);
        AWVALID = 1'b1;
        @(posedge ACLK);
        #1;
        AWVALID = 1'b0;
    endtask

    // Data-stage FIFO and AHB slave stall model; inputs change 1 time unit after the clock edge
    initial begin
        bit p;
        forever begin
            @(negedge ACLK);
            p = ctrl_wdata_valid_o;
            @(posedge ACLK);
            #1;
            if (p && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (src_q.size() > 0 && $urandom_range(0, 2) != 0) fifo_q.push_back(src_q.pop_front());
            HREADY             = $urandom_range(0, 3) != 0;
            ctrl_wdata_ready_i = fifo_q.size() > 0;
            ctrl_wdata_last_i  = fifo_q.size() > 0 ? fifo_q[0] : 1'b0;
        end
    end

    cmd_t cur;
    bit   active = 0, err_exp = 0;
    int   pops = 0, gap = 0;

    always @(negedge ACLK) begin
        beat_t      b;
        logic [1:0] exp_tr;
        if (!ARESETN) begin
            active = 0;
        end else begin
            if (active && AWREADY) begin
                check("tail_gap", gap, 3);
                check("pop_count", pops, cur.len + 1);
                check("final_err", cmd_error_o, cur.err_final);
                active = 0;
            end
            if (active) begin
                check("cmd_id", cmd_id_o, cur.id);
                check("cmd_error", cmd_error_o, err_exp);
                if (HWRITE) begin
                    exp_tr = ctrl_wdata_ready_i ?
                             ((pops == 0 || cur.burst == 0 || (cur.burst == 2 && cur.len == 1)) ? 2'b10 : 2'b11) :
                             (pops == 0 ? 2'b00 : 2'b01);
                    check("htrans", HTRANS, exp_tr);
                    check("addr_pop", ctrl_wdata_valid_o, ctrl_wdata_ready_i && HREADY);
                    if (HTRANS[1] && HREADY) begin
                        if (beat_q.size() == 0) flag("beat_unexpected");
                        else begin
                            b = beat_q.pop_front();
                            check("haddr", HADDR, b.addr);
                            check("hburst", HBURST, b.burst);
                            check("hsize", HSIZE, b.size);
                        end
                    end
                end else begin
                    check("htrans_idle", HTRANS, 0);
                end
                if (pops == cur.len + 1) gap++;
                if (ctrl_wdata_valid_o) begin
                    if (pops > cur.len) flag("pop_overrun");
                    if (ctrl_wdata_last_i != (pops == cur.len)) err_exp = 1;
                    pops++;
                    gap = 0;
                end
            end else if (!AWVALID) begin
                check("idle_no_pop", ctrl_wdata_valid_o, 0);
            end
            if (AWVALID && AWREADY) begin
                if (cmd_q.size() == 0) flag("aw_unexpected");
                else begin
                    cur     = cmd_q.pop_front();
                    active  = 1;
                    pops    = 0;
                    gap     = 0;
                    err_exp = cur.err;
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_reset();
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        issue(1, 32'h100, 3, 2, -1);
        issue(1, 32'h100, 3, 2, -1);
        issue(1, 32'h200, 1, 3, -1);
        issue(2, 32'h38, 3, 2, -1);
        issue(1, 32'h400, 3, 2, 1);
        issue(0, 32'h80, 2, 1, -1);
        issue(2, 32'h44, 3, 2, -1);
        issue(2, 32'h40, 2, 2, -1);
        for (int n = 0; n < 60; n++) begin
            int          br, len, size, flip;
            logic [31:0] a;
            br   = $urandom_range(0, 9);
            br   = br < 4 ? 1 : br < 7 ? 2 : br < 9 ? 0 : 3;
            len  = $urandom_range(0, 1) != 0 ? (1 << $urandom_range(1, 4)) - 1 : $urandom_range(0, 15);
            size = $urandom_range(0, 5) == 0 ? 3 : $urandom_range(0, 2);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << size) - 1);
            flip = $urandom_range(0, 7) == 0 ? $urandom_range(0, len) : -1;
            issue(br, a, len, size, flip);
        end
        wait_idle();
        @(negedge ACLK);
        check("beats_left", beat_q.size(), 0);
        check("cmds_left", cmd_q.size(), 0);
        issue(1, 32'h1000, 15, 2, -1);
        repeat (6) @(negedge ACLK);
        @(posedge ACLK);
        #1;
        ARESETN = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        beat_q.delete();
        src_q.delete();
        fifo_q.delete();
        check_reset();
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        repeat (3) @(negedge ACLK);
        check("post_rst_awready", AWREADY, 1);
        check("post_rst_htrans", HTRANS, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
